// File: rtl/r4_ctrl_pkg.sv
// Shared types and encodings for the R4 multi-cycle control path.
package r4_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] PRE_ADD    = 2'b00;
    localparam logic [1:0] PRE_SUB    = 2'b01;
    localparam logic [1:0] PRE_FUNCT  = 2'b10;
    localparam logic [1:0] PRE_FUNCT3 = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory request port.
interface multicycle_controller_if;

    logic memReq;
    logic memWrite;
    logic addrSrc;
    logic memReady;

    modport master (
        output memReq,
        output memWrite,
        output addrSrc,
        input  memReady
    );

    modport slave (
        input  memReq,
        input  memWrite,
        input  addrSrc,
        output memReady
    );

endinterface

// File: rtl/multicycle_controller.sv
// R4 multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port and counts retired instructions.
module multicycle_controller
    import r4_ctrl_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opCode,
    input  logic [2:0]         funct3,
    input  logic               zero,
    multicycle_controller_if.master mem,
    output logic               irWrite,
    output logic               pcWrite,
    output logic               pcSrc,
    output logic               aluSrc,
    output logic [1:0]         preAluOp,
    output logic               aluOutWrite,
    output logic               regWrite,
    output logic               memToReg,
    output logic               halt,
    output logic [COUNT_W-1:0] instret
);

    state_t state, next;
    logic retire;
    logic [COUNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= next;
            if (retire) count <= count + COUNT_W'(1);
        end
    end

    // Outputs are forced low for the whole reset cycle, including the count.
    assign instret = reset ? '0 : count;

    always_comb begin
        next         = state;
        retire       = 1'b0;
        mem.memReq   = 1'b0;
        mem.memWrite = 1'b0;
        mem.addrSrc  = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSrc        = 1'b0;
        aluSrc       = 1'b0;
        preAluOp     = PRE_ADD;
        aluOutWrite  = 1'b0;
        regWrite     = 1'b0;
        memToReg     = 1'b0;
        halt         = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    mem.memReq = 1'b1;
                    if (mem.memReady) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                        next    = DECODE;
                    end
                end
                DECODE: begin
                    case (opCode)
                        OP_LOAD, OP_STORE: next = MEMADR;
                        OP_REG:            next = EXEC_R;
                        OP_IMM:            next = EXEC_I;
                        OP_BRANCH:
                            next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                        default:           next = TRAP;
                    endcase
                end
                MEMADR: begin
                    aluOutWrite = 1'b1;
                    next = (opCode == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    mem.memReq  = 1'b1;
                    mem.addrSrc = 1'b1;
                    if (mem.memReady) next = MEMWB;
                end
                MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                    retire   = 1'b1;
                    next     = FETCH;
                end
                MEMWRITE: begin
                    mem.memReq   = 1'b1;
                    mem.memWrite = 1'b1;
                    mem.addrSrc  = 1'b1;
                    if (mem.memReady) begin
                        retire = 1'b1;
                        next   = FETCH;
                    end
                end
                EXEC_R: begin
                    aluSrc      = 1'b1;
                    preAluOp    = PRE_FUNCT;
                    aluOutWrite = 1'b1;
                    next        = ALUWB;
                end
                EXEC_I: begin
                    preAluOp    = PRE_FUNCT3;
                    aluOutWrite = 1'b1;
                    next        = ALUWB;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                    next     = FETCH;
                end
                BRANCH: begin
                    aluSrc   = 1'b1;
                    preAluOp = PRE_SUB;
                    // beq taken on zero, bne taken on non-zero
                    pcWrite  = zero ^ funct3[0];
                    pcSrc    = zero ^ funct3[0];
                    retire   = 1'b1;
                    next     = FETCH;
                end
                TRAP: begin
                    halt = 1'b1;
                end
                default: next = TRAP;
            endcase
        end
    end

endmodule
